ex_div: RTL and testbench

//   Multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU).
//   EX launches it from the operands and aluop registered by the ID/EX

---
 rtl/ex_div.sv | 118 +++++++++++
 tb/tb_ex_div.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle radix-2 restoring divider for EX-stage DIV/DIVU
// Produces {remainder, quotient}; quotient truncates toward zero, remainder takes the dividend sign.
module ex_div #(
    parameter int DATA_W = 32
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] divisor;
    logic              neg_quo;
    logic              neg_rem;

    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;
    logic              borrow;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;
    logic [DATA_W-1:0] rem_fix;
    logic [DATA_W-1:0] quo_fix;

    // Signed operands are divided as magnitudes; signs are restored at the end.
    assign mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // The full remainder is kept in the trial subtraction so divisors above 2^(W-1) still work.
    assign shifted  = {rem, quo[DATA_W-1]};
    assign trial    = shifted - {1'b0, divisor};
    assign borrow   = trial[DATA_W];
    assign rem_next = borrow ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
    assign quo_next = {quo[DATA_W-2:0], ~borrow};

    assign rem_fix  = neg_rem ? -rem : rem;
    assign quo_fix  = neg_quo ? -quo : quo;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= S_FREE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                S_FREE: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= S_BYZERO;
                        end else begin
                            state   <= S_ON;
                            cnt     <= '0;
                            rem     <= '0;
                            quo     <= mag1;
                            divisor <= mag2;
                            neg_quo <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                            neg_rem <= signed_div_i && opdata1_i[DATA_W-1];
                        end
                    end
                end
                S_BYZERO: begin
                    state    <= S_END;
                    result_o <= '0;
                    ready_o  <= 1'b1;
                end
                S_ON: begin
                    if (annul_i) begin
                        state   <= S_FREE;
                        ready_o <= 1'b0;
                    end else if (cnt != CNT_W'(DATA_W)) begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + 1'b1;
                    end else begin
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= 1'b1;
                        state    <= S_END;
                    end
                end
                S_END: begin
                    // Result is held for EX until it drops its request.
                    if (!start_i) begin
                        state    <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: state <= S_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - scoreboard bench for ex_div with randomized DIV/DIVU operations
module tb_ex_div;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic ready_q = 1'b0;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    ex_div #(.DATA_W(32)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: divide magnitudes with plain arithmetic, then apply the sign rules.
    function automatic logic [63:0] model(input bit sd, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, q, r;
        bit na, nb;
        if (b == 0) return 64'd0;
        na = sd && a[31];
        nb = sd && b[31];
        ma = na ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        mb = nb ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
        q = ma / mb;
        r = ma % mb;
        if (na != nb) q = 64'h1_0000_0000 - q;
        if (na) r = 64'h1_0000_0000 - r;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: every rising ready_o must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (ready_o && !ready_q) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result_o, e.res);
                check("latency", 64'(cyc), 64'(e.cyc));
            end
        end
        ready_q <= ready_o;
    end

    task automatic run_op(input bit sd, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit drop_early);
        logic [63:0] exp;
        exp = model(sd, a, b);
        @(negedge Clk);
        signed_div_i = sd;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        sb.push_back('{exp, cyc + ((b == 0) ? 2 : 34)});
        @(negedge Clk);
        // Operand ports must be ignored once captured.
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = $urandom_range(0, 1);
        if (drop_early) start_i = 1'b0;
        for (int i = 0; i < 60 && !ready_o; i++) @(negedge Clk);
        if (!ready_o) begin
            check("ready_timeout", 64'd0, 64'd1);
            sb.delete();
        end else if (!drop_early) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge Clk);
                check("hold_ready", 64'(ready_o), 64'd1);
                check("hold_result", result_o, exp);
            end
        end
        start_i = 1'b0;
        @(negedge Clk);
        check("drop_ready", 64'(ready_o), 64'd0);
        check("drop_result", result_o, 64'd0);
    endtask

    initial begin
        bit quiet;
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;

        run_op(1'b0, 32'd100, 32'd7, 3, 1'b0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1, 1'b0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1, 1'b0);
        run_op(1'b0, 32'd12345, 32'd0, 2, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 1'b0);
        run_op(1'b1, 32'd1000, 32'd9, 0, 1'b1);

        // Annul at cnt=10: the aborted division must never report.
        @(negedge Clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (11) @(negedge Clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge Clk);
        annul_i = 1'b0;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge Clk);
            if (ready_o) quiet = 1'b0;
        end
        check("annul_quiet", 64'(quiet), 64'd1);
        run_op(1'b0, 32'd9, 32'd3, 1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = b >> $urandom_range(1, 31);
                1: b = 32'd0;
                2: a = a >> $urandom_range(1, 31);
                3: b = (b[0]) ? 32'hFFFF_FFFF : 32'h8000_0000;
                default: ;
            endcase
            run_op(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset in the middle of a division.
        @(negedge Clk);
        signed_div_i = 1'b1; opdata1_i = 32'hFFFF_0000; opdata2_i = 32'd17; start_i = 1'b1;
        repeat (15) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        check("rst_on_ready", 64'(ready_o), 64'd0);
        check("rst_on_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge Clk);
            if (ready_o) quiet = 1'b0;
        end
        check("rst_on_quiet", 64'(quiet), 64'd1);

        // Asynchronous reset while a result is being held.
        @(negedge Clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        sb.push_back('{model(1'b0, 32'd100, 32'd7), cyc + 34});
        for (int i = 0; i < 60 && !ready_o; i++) @(negedge Clk);
        check("end_ready_seen", 64'(ready_o), 64'd1);
        #2 Rst_n = 1'b0;
        #1;
        check("rst_end_ready", 64'(ready_o), 64'd0);
        check("rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        run_op(1'b0, 32'd9, 32'd3, 1, 1'b0);

        repeat (3) @(negedge Clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
